// File: rtl/spike_injector_pkg.sv
// spike_injector_pkg: FSM encoding, clog2 and flit field offsets shared by the injector.
package spike_injector_pkg;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        LOOKUP = 2'd1,
        EMIT   = 2'd2
    } state_e;

    // Never returns 0 so a one-row or one-column mesh still gets a real field.
    function automatic int clog2(input int n);
        int r;
        r = 0;
        while ((1 << r) < n) r++;
        return (r == 0) ? 1 : r;
    endfunction

    function automatic int dest_row_lsb(input int dw, input int rows);
        return dw - clog2(rows);
    endfunction

    function automatic int dest_col_lsb(input int dw, input int rows, input int cols);
        return dest_row_lsb(dw, rows) - clog2(cols);
    endfunction

    function automatic int src_row_lsb(input int dw, input int rows, input int cols);
        return dest_col_lsb(dw, rows, cols) - clog2(rows);
    endfunction

    function automatic int src_col_lsb(input int dw, input int rows, input int cols);
        return src_row_lsb(dw, rows, cols) - clog2(cols);
    endfunction

endpackage

// File: rtl/spike_injector_if.sv
// spike_injector_if: CPU spike store port and router local-port flit handshake.
interface spike_injector_if #(
    parameter int NEURON_ID_W = 8,
    parameter int DATA_WIDTH  = 32
);
    logic                   spike_valid;
    logic [NEURON_ID_W-1:0] spike_neuron_id;
    logic                   spike_busywait;
    logic [DATA_WIDTH-1:0]  flit_out;
    logic                   flit_valid;
    logic                   flit_ready;

    modport master (
        output spike_valid, spike_neuron_id, flit_ready,
        input  spike_busywait, flit_out, flit_valid
    );

    modport slave (
        input  spike_valid, spike_neuron_id, flit_ready,
        output spike_busywait, flit_out, flit_valid
    );
endinterface

// File: rtl/spike_fifo.sv
// spike_fifo: synchronous FIFO of neuron ids with wrap-bit full/empty detection.
module spike_fifo
    import spike_injector_pkg::*;
#(
    parameter int WIDTH = 8,
    parameter int DEPTH = 4
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             push_i,
    input  logic             pop_i,
    input  logic [WIDTH-1:0] wdata_i,
    output logic [WIDTH-1:0] rdata_o,
    output logic             full_o,
    output logic             empty_o
);
    localparam int AW = clog2(DEPTH);

    logic [WIDTH-1:0] mem_q [DEPTH];
    logic [AW:0]      wr_q, rd_q;

    assign empty_o = wr_q == rd_q;
    assign full_o  = (wr_q[AW] != rd_q[AW]) && (wr_q[AW-1:0] == rd_q[AW-1:0]);
    assign rdata_o = mem_q[rd_q[AW-1:0]];

    always_ff @(posedge clk) begin
        if (!rst) begin
            wr_q <= '0;
            rd_q <= '0;
        end else begin
            if (push_i) begin
                mem_q[wr_q[AW-1:0]] <= wdata_i;
                wr_q                <= wr_q + 1'b1;
            end
            if (pop_i) rd_q <= rd_q + 1'b1;
        end
    end
endmodule

// File: rtl/spike_injector.sv
// spike_injector: buffers CPU spike events, looks up their multicast mask and
// serialises one single-flit packet per destination node into the local router port.
module spike_injector
    import spike_injector_pkg::*;
#(
    parameter int ROWS        = 4,
    parameter int COLS        = 4,
    parameter int DATA_WIDTH  = 32,
    parameter int NEURON_ID_W = 8,
    parameter int FIFO_DEPTH  = 4,
    parameter int MY_ROW      = 0,
    parameter int MY_COL      = 0
) (
    input  logic                   clk,
    input  logic                   rst,
    spike_injector_if.slave        bus,
    input  logic                   cfg_we,
    input  logic [NEURON_ID_W-1:0] cfg_addr,
    input  logic [ROWS*COLS-1:0]   cfg_wdata,
    output logic                   idle,
    output logic [15:0]            flit_count
);
    localparam int N  = ROWS * COLS;
    localparam int RW = clog2(ROWS);
    localparam int CW = clog2(COLS);
    localparam int IW = clog2(N);
    localparam int DR = dest_row_lsb(DATA_WIDTH, ROWS);
    localparam int DC = dest_col_lsb(DATA_WIDTH, ROWS, COLS);
    localparam int SR = src_row_lsb(DATA_WIDTH, ROWS, COLS);
    localparam int SC = src_col_lsb(DATA_WIDTH, ROWS, COLS);

    logic [N-1:0]           table_q [2**NEURON_ID_W];
    state_e                 state_q, state_d;
    logic [N-1:0]           mask_q, mask_d;
    logic [NEURON_ID_W-1:0] id_q, id_d, head;
    logic [15:0]            count_q;
    logic                   full, empty, pop, fire;
    logic [IW-1:0]          tgt;
    logic [DATA_WIDTH-1:0]  flit;

    spike_fifo #(.WIDTH(NEURON_ID_W), .DEPTH(FIFO_DEPTH)) u_fifo (
        .clk     (clk),
        .rst     (rst),
        .push_i  (bus.spike_valid && !full),
        .pop_i   (pop),
        .wdata_i (bus.spike_neuron_id),
        .rdata_o (head),
        .full_o  (full),
        .empty_o (empty)
    );

    assign fire               = (state_q == EMIT) && bus.flit_ready;
    assign bus.flit_valid     = state_q == EMIT;
    assign bus.flit_out       = (state_q == EMIT) ? flit : '0;
    assign bus.spike_busywait = full;
    assign idle               = empty && (state_q == IDLE);
    assign flit_count         = count_q;

    always_comb begin
        tgt = '0;
        for (int i = N - 1; i >= 0; i--) if (mask_q[i]) tgt = IW'(i);
    end

    always_comb begin
        flit                  = '0;
        flit[DR +: RW]        = RW'(int'(tgt) / COLS);
        flit[DC +: CW]        = CW'(int'(tgt) % COLS);
        flit[SR +: RW]        = RW'(MY_ROW);
        flit[SC +: CW]        = CW'(MY_COL);
        flit[NEURON_ID_W-1:0] = id_q;
    end

    // mask & (mask - 1) drops exactly the lowest set bit, i.e. the target just accepted.
    always_comb begin
        state_d = state_q;
        mask_d  = mask_q;
        id_d    = id_q;
        pop     = 1'b0;
        case (state_q)
            IDLE: if (!empty) begin
                pop     = 1'b1;
                id_d    = head;
                state_d = LOOKUP;
            end
            LOOKUP: begin
                mask_d  = table_q[id_q];
                state_d = (table_q[id_q] == '0) ? IDLE : EMIT;
            end
            EMIT: if (fire) begin
                mask_d  = mask_q & (mask_q - 1'b1);
                state_d = ((mask_q & (mask_q - 1'b1)) == '0) ? IDLE : EMIT;
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!rst) begin
            state_q <= IDLE;
            mask_q  <= '0;
            id_q    <= '0;
            count_q <= '0;
            for (int i = 0; i < 2**NEURON_ID_W; i++) table_q[i] <= '0;
        end else begin
            state_q <= state_d;
            mask_q  <= mask_d;
            id_q    <= id_d;
            if (fire) count_q <= count_q + 16'd1;
            if (cfg_we) table_q[cfg_addr] <= cfg_wdata;
        end
    end
endmodule

// File: tb/tb_spike_injector.sv
// tb_spike_injector: directed scenarios for spike_injector with hand-computed flits.
module tb_spike_injector;
    logic        clk = 1'b0;
    logic        rst = 1'b0;
    logic        cfg_we;
    logic [7:0]  cfg_addr;
    logic [15:0] cfg_wdata;
    logic        idle;
    logic [15:0] flit_count;
    int          n_checks = 0;
    int          n_fail = 0;
    int          exp_cnt = 0;

    always #5 clk = ~clk;

    spike_injector_if #(.NEURON_ID_W(8), .DATA_WIDTH(32)) bus ();

    spike_injector #(
        .ROWS(4), .COLS(4), .DATA_WIDTH(32), .NEURON_ID_W(8),
        .FIFO_DEPTH(4), .MY_ROW(0), .MY_COL(0)
    ) dut (
        .clk        (clk),
        .rst        (rst),
        .bus        (bus),
        .cfg_we     (cfg_we),
        .cfg_addr   (cfg_addr),
        .cfg_wdata  (cfg_wdata),
        .idle       (idle),
        .flit_count (flit_count)
    );

    task automatic tick;
        @(posedge clk);
        #1;
    endtask

    task automatic cfg_write(input logic [7:0] a, input logic [15:0] d);
        cfg_we = 1'b1; cfg_addr = a; cfg_wdata = d;
        tick();
        cfg_we = 1'b0;
    endtask

    task automatic push(input logic [7:0] id);
        bus.spike_valid = 1'b1; bus.spike_neuron_id = id;
        tick();
        bus.spike_valid = 1'b0;
    endtask

    task automatic test_reset;
        bus.spike_valid = 0; bus.spike_neuron_id = 0; bus.flit_ready = 1;
        cfg_we = 0; cfg_addr = 0; cfg_wdata = 0; rst = 0;
        tick(); tick(); rst = 1; tick();
        n_checks++; if (bus.flit_valid !== 1'b0) begin n_fail++; $display("FAIL reset_valid: got %b want 0", bus.flit_valid); end
        n_checks++; if (bus.flit_out !== 32'h0) begin n_fail++; $display("FAIL reset_out: got %h want 0", bus.flit_out); end
        n_checks++; if (flit_count !== 16'd0) begin n_fail++; $display("FAIL reset_count: got %0d want 0", flit_count); end
        n_checks++; if (bus.spike_busywait !== 1'b0) begin n_fail++; $display("FAIL reset_busy: got %b want 0", bus.spike_busywait); end
        n_checks++; if (idle !== 1'b1) begin n_fail++; $display("FAIL reset_idle: got %b want 1", idle); end
    endtask

    task automatic test_unicast;
        cfg_write(8'd5, 16'h0020);
        bus.flit_ready = 1;
        push(8'd5);
        n_checks++; if (bus.flit_valid !== 1'b0) begin n_fail++; $display("FAIL uni_c1_valid: got %b want 0", bus.flit_valid); end
        tick();
        n_checks++; if (bus.flit_valid !== 1'b0) begin n_fail++; $display("FAIL uni_c2_valid: got %b want 0", bus.flit_valid); end
        tick();
        n_checks++; if (bus.flit_valid !== 1'b1 || bus.flit_out !== 32'h5000_0005) begin n_fail++; $display("FAIL uni_c3_flit: got v=%b %h want v=1 50000005", bus.flit_valid, bus.flit_out); end
        tick();
        exp_cnt = 1;
        n_checks++; if (bus.flit_valid !== 1'b0) begin n_fail++; $display("FAIL uni_c4_valid: got %b want 0", bus.flit_valid); end
        n_checks++; if (flit_count !== 16'(exp_cnt)) begin n_fail++; $display("FAIL uni_count: got %0d want %0d", flit_count, exp_cnt); end
        n_checks++; if (idle !== 1'b1) begin n_fail++; $display("FAIL uni_idle: got %b want 1", idle); end
    endtask

    task automatic test_multicast_backpressure;
        cfg_write(8'd7, 16'h8001);
        bus.flit_ready = 0;
        push(8'd7);
        tick(); tick();
        for (int k = 0; k < 4; k++) begin
            n_checks++; if (bus.flit_valid !== 1'b1 || bus.flit_out !== 32'h0000_0007) begin n_fail++; $display("FAIL mc_hold%0d: got v=%b %h want v=1 00000007", k, bus.flit_valid, bus.flit_out); end
            tick();
        end
        bus.flit_ready = 1;
        n_checks++; if (bus.flit_out !== 32'h0000_0007) begin n_fail++; $display("FAIL mc_first: got %h want 00000007", bus.flit_out); end
        tick();
        n_checks++; if (bus.flit_valid !== 1'b1 || bus.flit_out !== 32'hF000_0007) begin n_fail++; $display("FAIL mc_second: got v=%b %h want v=1 F0000007", bus.flit_valid, bus.flit_out); end
        tick();
        exp_cnt += 2;
        n_checks++; if (bus.flit_valid !== 1'b0) begin n_fail++; $display("FAIL mc_done_valid: got %b want 0", bus.flit_valid); end
        n_checks++; if (flit_count !== 16'(exp_cnt)) begin n_fail++; $display("FAIL mc_count: got %0d want %0d", flit_count, exp_cnt); end
    endtask

    task automatic test_fifo_full;
        int n;
        cfg_write(8'd1, 16'h0001);
        bus.flit_ready = 0;
        bus.spike_valid = 1; bus.spike_neuron_id = 8'd1;
        tick(); tick(); tick(); tick();
        n_checks++; if (bus.spike_busywait !== 1'b0) begin n_fail++; $display("FAIL full_three: got %b want 0", bus.spike_busywait); end
        tick();
        n_checks++; if (bus.spike_busywait !== 1'b1) begin n_fail++; $display("FAIL full_four: got %b want 1", bus.spike_busywait); end
        tick();
        n_checks++; if (bus.spike_busywait !== 1'b1) begin n_fail++; $display("FAIL full_hold: got %b want 1", bus.spike_busywait); end
        n_checks++; if (bus.flit_valid !== 1'b1 || bus.flit_out !== 32'h0000_0001) begin n_fail++; $display("FAIL full_flit: got v=%b %h want v=1 00000001", bus.flit_valid, bus.flit_out); end
        bus.flit_ready = 1;
        tick();
        n_checks++; if (bus.spike_busywait !== 1'b1 || bus.flit_valid !== 1'b0) begin n_fail++; $display("FAIL full_pop_cycle: got busy=%b v=%b want busy=1 v=0", bus.spike_busywait, bus.flit_valid); end
        tick();
        bus.spike_valid = 0;
        n_checks++; if (bus.spike_busywait !== 1'b0) begin n_fail++; $display("FAIL full_after_pop: got %b want 0", bus.spike_busywait); end
        n = 1;
        for (int c = 0; c < 40 && idle !== 1'b1; c++) begin
            if (bus.flit_valid === 1'b1) begin
                n++;
                n_checks++; if (bus.flit_out !== 32'h0000_0001) begin n_fail++; $display("FAIL full_drain_flit: got %h want 00000001", bus.flit_out); end
            end
            tick();
        end
        exp_cnt += 5;
        n_checks++; if (idle !== 1'b1) begin n_fail++; $display("FAIL full_drain_timeout: idle=%b want 1", idle); end
        n_checks++; if (n !== 5) begin n_fail++; $display("FAIL full_flits: got %0d want 5", n); end
        n_checks++; if (flit_count !== 16'(exp_cnt)) begin n_fail++; $display("FAIL full_count: got %0d want %0d", flit_count, exp_cnt); end
    endtask

    task automatic test_empty_mask;
        push(8'd9);
        n_checks++; if (bus.flit_valid !== 1'b0) begin n_fail++; $display("FAIL empty_c1: got %b want 0", bus.flit_valid); end
        tick();
        n_checks++; if (bus.flit_valid !== 1'b0 || idle !== 1'b0) begin n_fail++; $display("FAIL empty_lookup: got v=%b idle=%b want v=0 idle=0", bus.flit_valid, idle); end
        tick();
        n_checks++; if (bus.flit_valid !== 1'b0 || idle !== 1'b1) begin n_fail++; $display("FAIL empty_back: got v=%b idle=%b want v=0 idle=1", bus.flit_valid, idle); end
        n_checks++; if (flit_count !== 16'(exp_cnt)) begin n_fail++; $display("FAIL empty_count: got %0d want %0d", flit_count, exp_cnt); end
    endtask

    task automatic test_collision;
        cfg_write(8'd3, 16'h0004);
        bus.flit_ready = 1;
        push(8'd3);
        tick();
        cfg_we = 1; cfg_addr = 8'd3; cfg_wdata = 16'h0002;
        tick();
        cfg_we = 0;
        n_checks++; if (bus.flit_valid !== 1'b1 || bus.flit_out !== 32'h2000_0003) begin n_fail++; $display("FAIL coll_old: got v=%b %h want v=1 20000003", bus.flit_valid, bus.flit_out); end
        tick();
        push(8'd3);
        tick(); tick();
        n_checks++; if (bus.flit_valid !== 1'b1 || bus.flit_out !== 32'h1000_0003) begin n_fail++; $display("FAIL coll_new: got v=%b %h want v=1 10000003", bus.flit_valid, bus.flit_out); end
        tick();
        exp_cnt += 2;
        n_checks++; if (flit_count !== 16'(exp_cnt)) begin n_fail++; $display("FAIL coll_count: got %0d want %0d", flit_count, exp_cnt); end
    endtask

    task automatic test_back_to_back;
        logic [31:0] exp_o [7];
        exp_o = '{32'h0, 32'h0000_0007, 32'hF000_0007, 32'h0, 32'h0, 32'h5000_0005, 32'h0};
        bus.flit_ready = 1;
        bus.spike_valid = 1; bus.spike_neuron_id = 8'd7;
        tick();
        bus.spike_neuron_id = 8'd5;
        tick();
        bus.spike_valid = 0;
        for (int k = 0; k < 7; k++) begin
            n_checks++;
            if (bus.flit_valid !== (exp_o[k] != 0) || (exp_o[k] != 0 && bus.flit_out !== exp_o[k])) begin
                n_fail++; $display("FAIL b2b_c%0d: got v=%b %h want %h", k + 2, bus.flit_valid, bus.flit_out, exp_o[k]);
            end
            tick();
        end
        exp_cnt += 3;
        n_checks++; if (flit_count !== 16'(exp_cnt)) begin n_fail++; $display("FAIL b2b_count: got %0d want %0d", flit_count, exp_cnt); end
    endtask

    task automatic test_reset_mid_emit;
        cfg_write(8'd2, 16'h0003);
        bus.flit_ready = 0;
        push(8'd2);
        tick(); tick();
        n_checks++; if (bus.flit_valid !== 1'b1) begin n_fail++; $display("FAIL rme_pre: got %b want 1", bus.flit_valid); end
        rst = 0;
        tick();
        rst = 1;
        exp_cnt = 0;
        n_checks++; if (bus.flit_valid !== 1'b0 || bus.flit_out !== 32'h0) begin n_fail++; $display("FAIL rme_flit: got v=%b %h want v=0 0", bus.flit_valid, bus.flit_out); end
        n_checks++; if (idle !== 1'b1) begin n_fail++; $display("FAIL rme_idle: got %b want 1", idle); end
        n_checks++; if (flit_count !== 16'(exp_cnt)) begin n_fail++; $display("FAIL rme_count: got %0d want 0", flit_count); end
        bus.flit_ready = 1;
        push(8'd2);
        tick(); tick();
        n_checks++; if (bus.flit_valid !== 1'b0 || idle !== 1'b1) begin n_fail++; $display("FAIL rme_table: got v=%b idle=%b want v=0 idle=1", bus.flit_valid, idle); end
    endtask

    initial begin
        test_reset();
        test_unicast();
        test_multicast_backpressure();
        test_fifo_full();
        test_empty_mask();
        test_collision();
        test_back_to_back();
        test_reset_mid_emit();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1);
    end
endmodule
